// File: rtl/simple_proc_pkg.sv
// Shared opcode/state encodings for the simple_proc_core datapath.
package simple_proc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MV   = 3'd0,
        OP_MVI  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_MVNZ = 3'd6,
        OP_NOP  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EX1  = 3'd1,
        EX2  = 3'd2,
        EX3  = 3'd3
    } state_t;

endpackage

// File: rtl/simple_proc_alu.sv
// Combinational ALU: add/sub with carry-out, bitwise and/or, zero detect.
module simple_proc_alu
    import simple_proc_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  opcode_t           op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);
    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            // carry out of A + ~B + 1 is 1 exactly when no borrow occurs
            OP_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/simple_proc_core.sv
// Multi-cycle core: register file, A/G accumulators, shared bus and control FSM.
module simple_proc_core
    import simple_proc_pkg::*;
#(
    parameter  int DATA_W = 9,
    parameter  int NREG   = 8,
    localparam int RW     = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] DIN,
    input  logic              run,
    output logic              Done,
    output logic              busy,
    output logic [2:0]        state,
    output logic [DATA_W-1:0] BUS,
    output logic [DATA_W-1:0] G,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [RW-1:0]     dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int IR_W = OP_W + 2 * RW;

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] regs [NREG];
    opcode_t           op;
    logic [RW-1:0]     rx, ry;
    logic              is_alu;
    logic              wr_en, a_en, g_en;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry, alu_zero;

    // Only the op/RX/RY fields are kept; lower instruction bits are don't-care.
    assign op     = opcode_t'(ir[IR_W-1 -: OP_W]);
    assign rx     = ir[IR_W-OP_W-1 -: RW];
    assign ry     = ir[RW-1:0];
    assign is_alu = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        Done    = 1'b0;
        BUS     = '0;
        wr_en   = 1'b0;
        a_en    = 1'b0;
        g_en    = 1'b0;
        case (state_q)
            IDLE: if (run) state_d = EX1;
            EX1: begin
                state_d = is_alu ? EX2 : IDLE;
                Done    = !is_alu;
                case (op)
                    OP_MV: begin
                        BUS   = regs[ry];
                        wr_en = 1'b1;
                    end
                    OP_MVI: begin
                        BUS   = DIN;
                        wr_en = 1'b1;
                    end
                    OP_MVNZ: begin
                        BUS   = regs[ry];
                        wr_en = !flag_z;
                    end
                    OP_NOP: begin
                        BUS = '0;
                    end
                    default: begin
                        BUS  = regs[rx];
                        a_en = 1'b1;
                    end
                endcase
            end
            EX2: begin
                BUS     = regs[ry];
                g_en    = 1'b1;
                state_d = EX3;
            end
            EX3: begin
                BUS     = G;
                wr_en   = 1'b1;
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir     <= '0;
            a_reg  <= '0;
            G      <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (state_q == IDLE && run) ir <= DIN[DATA_W-1 -: IR_W];
            if (a_en) a_reg <= BUS;
            if (g_en) begin
                G      <= alu_result;
                flag_z <= alu_zero;
                flag_c <= alu_carry;
            end
            if (wr_en) regs[rx] <= BUS;
        end
    end

    simple_proc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (BUS),
        .op     (op),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    assign state    = state_q;
    assign busy     = (state_q != IDLE);
    assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_simple_proc_core.sv
// Scoreboard bench for simple_proc_core at 9-bit/8-reg and 16-bit/16-reg widths.
module tb_simple_proc_core;
    import simple_proc_pkg::*;

    typedef struct {
        string       name;
        int unsigned ridx;
        logic [15:0] val;
        bit          chkf;
        bit          z;
        bit          c;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [8:0]  din9 = '0, bus9, g9, dbg9;
    logic        run9 = 1'b0, done9, busy9, z9, c9;
    logic [2:0]  st9, dsel9 = '0;

    logic [15:0] din16 = '0, bus16, g16, dbg16;
    logic        run16 = 1'b0, done16, busy16, z16, c16;
    logic [2:0]  st16;
    logic [3:0]  dsel16 = '0;

    int   total = 0;
    int   bad   = 0;
    exp_t q9[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    simple_proc_core #(.DATA_W(9), .NREG(8)) u_dut9 (
        .clk(clk), .rst(rst), .DIN(din9), .run(run9), .Done(done9), .busy(busy9),
        .state(st9), .BUS(bus9), .G(g9), .flag_z(z9), .flag_c(c9),
        .dbg_sel(dsel9), .dbg_data(dbg9)
    );

    simple_proc_core #(.DATA_W(16), .NREG(16)) u_dut16 (
        .clk(clk), .rst(rst), .DIN(din16), .run(run16), .Done(done16), .busy(busy16),
        .state(st16), .BUS(bus16), .G(g16), .flag_z(z16), .flag_c(c16),
        .dbg_sel(dsel16), .dbg_data(dbg16)
    );

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", n, act, req);
        end
    endtask

    function automatic logic [15:0] enc9(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {7'd0, op, rx, ry};
    endfunction

    function automatic logic [15:0] enc16(input logic [2:0] op, input logic [3:0] rx, input logic [3:0] ry);
        return {op, rx, ry, 5'd0};
    endfunction

    task automatic expect_done(input bit w, input string n, input int unsigned r, input logic [15:0] v,
                               input bit chkf, input bit z, input bit c, input int lat);
        exp_t e;
        e = '{name: n, ridx: r, val: v, chkf: chkf, z: z, c: c, lat: lat};
        if (w) q16.push_back(e);
        else   q9.push_back(e);
    endtask

    task automatic wait_idle(input bit w);
        int k = 0;
        while ((w ? busy16 : busy9) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_timeout", {31'd0, (w ? busy16 : busy9)}, 0);
    endtask

    task automatic issue(input bit w, input logic [15:0] instr, input logic [15:0] imm);
        if (w) begin din16 = instr; run16 = 1'b1; end
        else   begin din9 = instr[8:0]; run9 = 1'b1; end
        @(posedge clk); #1;
        run9  = 1'b0;
        run16 = 1'b0;
        if (w) din16 = imm;
        else   din9 = imm[8:0];
        wait_idle(w);
    endtask

    // Scoreboard monitor for the 9-bit core
    initial begin : mon9
        exp_t e;
        int   cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) cnt = 0;
            else if (done9) begin
                cnt++;
                if (q9.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done9 actual=1 required=0");
                end else begin
                    e = q9.pop_front();
                    check({e.name, "_lat"}, cnt, e.lat);
                    if (e.chkf) begin
                        check({e.name, "_z"}, {31'd0, z9}, {31'd0, e.z});
                        check({e.name, "_c"}, {31'd0, c9}, {31'd0, e.c});
                    end
                    dsel9 = e.ridx[2:0];
                    @(negedge clk);
                    check({e.name, "_reg"}, {23'd0, dbg9}, {16'd0, e.val});
                end
                cnt = 0;
            end else if (st9 == 3'd0) cnt = 0;
            else cnt++;
        end
    end

    // Scoreboard monitor for the 16-bit core
    initial begin : mon16
        exp_t e;
        int   cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) cnt = 0;
            else if (done16) begin
                cnt++;
                if (q16.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done16 actual=1 required=0");
                end else begin
                    e = q16.pop_front();
                    check({e.name, "_lat"}, cnt, e.lat);
                    if (e.chkf) begin
                        check({e.name, "_z"}, {31'd0, z16}, {31'd0, e.z});
                        check({e.name, "_c"}, {31'd0, c16}, {31'd0, e.c});
                    end
                    dsel16 = e.ridx[3:0];
                    @(negedge clk);
                    check({e.name, "_reg"}, {16'd0, dbg16}, {16'd0, e.val});
                end
                cnt = 0;
            end else if (st16 == 3'd0) cnt = 0;
            else cnt++;
        end
    end

    initial begin : stim
        logic [15:0] bb [4];
        int          cyc;
        int          k;

        #1;
        check("rst_state", {29'd0, st9}, 0);
        check("rst_done",  {31'd0, done9}, 0);
        check("rst_busy",  {31'd0, busy9}, 0);
        check("rst_g",     {23'd0, g9}, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        expect_done(0, "mvi_r0", 0, 16'd5, 0, 0, 0, 1);
        issue(0, enc9(OP_MVI, 3'd0, 3'd0), 16'd5);
        expect_done(0, "mv_r1_r0", 1, 16'd5, 0, 0, 0, 1);
        issue(0, enc9(OP_MV, 3'd1, 3'd0), 16'd0);

        expect_done(0, "mvi_r0_1ff", 0, 16'h1FF, 0, 0, 0, 1);
        issue(0, enc9(OP_MVI, 3'd0, 3'd0), 16'h1FF);
        expect_done(0, "mvi_r1_1", 1, 16'd1, 0, 0, 0, 1);
        issue(0, enc9(OP_MVI, 3'd1, 3'd0), 16'd1);
        expect_done(0, "add_carry", 0, 16'd0, 1, 1, 1, 3);
        issue(0, enc9(OP_ADD, 3'd0, 3'd1), 16'd0);

        expect_done(0, "mvi_r2", 2, 16'd7, 0, 0, 0, 1);
        issue(0, enc9(OP_MVI, 3'd2, 3'd0), 16'd7);
        expect_done(0, "mvi_r3", 3, 16'd3, 0, 0, 0, 1);
        issue(0, enc9(OP_MVI, 3'd3, 3'd0), 16'd3);
        expect_done(0, "sub_r2_r3", 2, 16'd4, 1, 0, 1, 3);
        issue(0, enc9(OP_SUB, 3'd2, 3'd3), 16'd0);
        expect_done(0, "mvnz_taken", 4, 16'd4, 1, 0, 1, 1);
        issue(0, enc9(OP_MVNZ, 3'd4, 3'd2), 16'd0);

        expect_done(0, "mvi_r5", 5, 16'd3, 0, 0, 0, 1);
        issue(0, enc9(OP_MVI, 3'd5, 3'd0), 16'd3);
        expect_done(0, "mvi_r6", 6, 16'd9, 0, 0, 0, 1);
        issue(0, enc9(OP_MVI, 3'd6, 3'd0), 16'd9);
        expect_done(0, "sub_self_zero", 5, 16'd0, 1, 1, 1, 3);
        issue(0, enc9(OP_SUB, 3'd5, 3'd5), 16'd0);
        expect_done(0, "mvnz_blocked", 4, 16'd4, 1, 1, 1, 1);
        issue(0, enc9(OP_MVNZ, 3'd4, 3'd6), 16'd0);
        expect_done(0, "add_self", 2, 16'd8, 1, 0, 0, 3);
        issue(0, enc9(OP_ADD, 3'd2, 3'd2), 16'd0);

        // back-to-back: run held high, 2+4+2+4 cycles with no bubble
        bb[0] = enc9(OP_MV,  3'd7, 3'd2);
        bb[1] = enc9(OP_ADD, 3'd7, 3'd2);
        bb[2] = enc9(OP_MV,  3'd6, 3'd7);
        bb[3] = enc9(OP_SUB, 3'd6, 3'd2);
        expect_done(0, "b2b_mv",  7, 16'd8,  1, 0, 0, 1);
        expect_done(0, "b2b_add", 7, 16'd16, 1, 0, 0, 3);
        expect_done(0, "b2b_mv2", 6, 16'd16, 1, 0, 0, 1);
        expect_done(0, "b2b_sub", 6, 16'd8,  1, 0, 1, 3);
        cyc  = 0;
        din9 = bb[0][8:0];
        run9 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (i == 3) run9 = 1'b0;
            else        din9 = bb[i+1][8:0];
            k = 0;
            while (busy9 && k < 10) begin
                @(posedge clk); #1;
                cyc++;
                k++;
            end
        end
        check("b2b_cycles", cyc, 12);

        // run pulsed while busy must not start the pending mv R0,R7
        expect_done(0, "add_busy_run", 7, 16'd24, 1, 0, 0, 3);
        din9 = enc9(OP_ADD, 3'd7, 3'd2)[8:0];
        run9 = 1'b1;
        @(posedge clk); #1;
        din9 = enc9(OP_MV, 3'd0, 3'd7)[8:0];
        @(posedge clk); #1;
        @(posedge clk); #1;
        run9 = 1'b0;
        wait_idle(0);
        expect_done(0, "mv_r1_r0_after", 1, 16'd0, 1, 0, 0, 1);
        issue(0, enc9(OP_MV, 3'd1, 3'd0), 16'd0);
        expect_done(0, "nop", 7, 16'd24, 1, 0, 0, 1);
        issue(0, enc9(OP_NOP, 3'd7, 3'd7), 16'd0);

        expect_done(1, "w16_mvi_r1", 1, 16'hF0F0, 0, 0, 0, 1);
        issue(1, enc16(OP_MVI, 4'd1, 4'd0), 16'hF0F0);
        expect_done(1, "w16_mvi_r2", 2, 16'h0FF0, 0, 0, 0, 1);
        issue(1, enc16(OP_MVI, 4'd2, 4'd0), 16'h0FF0);
        expect_done(1, "w16_mvi_r3", 3, 16'hF0F0, 0, 0, 0, 1);
        issue(1, enc16(OP_MVI, 4'd3, 4'd0), 16'hF0F0);
        expect_done(1, "w16_and", 1, 16'h00F0, 1, 0, 0, 3);
        issue(1, enc16(OP_AND, 4'd1, 4'd2), 16'd0);
        expect_done(1, "w16_or", 3, 16'hFFF0, 1, 0, 0, 3);
        issue(1, enc16(OP_OR, 4'd3, 4'd2), 16'd0);
        expect_done(1, "w16_mv_r15", 15, 16'hFFF0, 1, 0, 0, 1);
        issue(1, enc16(OP_MV, 4'd15, 4'd3), 16'd0);

        k = 0;
        while ((q9.size() + q16.size()) != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        check("queue_drain", q9.size() + q16.size(), 0);

        // async reset in EX2 of add R3,R2
        din9 = enc9(OP_ADD, 3'd3, 3'd2)[8:0];
        run9 = 1'b1;
        @(posedge clk); #1;
        run9 = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_ex2", {29'd0, st9}, 2);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_state", {29'd0, st9}, 0);
        check("mid_rst_g",     {23'd0, g9}, 0);
        check("mid_rst_done",  {31'd0, done9}, 0);
        check("mid_rst_busy",  {31'd0, busy9}, 0);
        check("mid_rst_g16",   {16'd0, g16}, 0);
        check("mid_rst_z",     {31'd0, z9}, 0);
        for (int i = 0; i < 8; i++) begin
            dsel9 = 3'(i);
            #1;
            check($sformatf("mid_rst_r%0d", i), {23'd0, dbg9}, 0);
        end
        dsel16 = 4'd15;
        #1;
        check("mid_rst_r15_w16", {16'd0, dbg16}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
